execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
Execute stage of the 5-stage RV32I pipeline, directly upstream of memory_cycle. It resolves the operands using forwarding selects, runs the ALU, and resolves beq branches combinationally. It registers the EX/MEM pipeline bundle that memory_cycle consumes. The EX/MEM register supports a hold (stall) and a bubble injection (flush).

Parameters:
XLEN, 32, datapath width
REGW, 5, register-index width

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
regwrt_E  in  1  register-write enable from ID/EX
memwrite_E  in  1  data-memory write enable
resultctrl_E  in  1  writeback select (0 = ALU, 1 = memory)
branch_E  in  1  instruction is beq
alusrc_E  in  1  ALU operand B select (0 = register, 1 = imm)
alucontrol_E  in  3  ALU operation
RD1_E  in  XLEN  rs1 value
RD2_E  in  XLEN  rs2 value
imm_E  in  XLEN  sign-extended immediate
RD_E  in  REGW  destination register
PC_E  in  XLEN  instruction PC
PC_1DE  in  XLEN  PC+4
forwardA_E  in  2  rs1 source select
forwardB_E  in  2  rs2 source select
result_W  in  XLEN  writeback result
stall_M  in  1  hold the EX/MEM register
flush_E  in  1  inject a bubble into EX/MEM
PCsrc_E  out  1  branch taken
PCtarget_E  out  XLEN  branch target
regwrt_M  out  1  registered regwrt
memwrite_M  out  1  registered memwrite
resultctrl_M  out  1  registered resultctrl
RD_M  out  REGW  registered destination register
PC_1DEM  out  XLEN  registered PC+4
writedata_M  out  XLEN  registered forwarded rs2
ALUresult_M  out  XLEN  registered ALU result

Behaviour:
- Reset is rst=1, asynchronous and active-high. While in reset, every *_M output is 0.
- PCsrc_E and PCtarget_E are combinational. In reset they follow their inputs; they are not forced.
- Operand forwarding, for srcA from forwardA_E:
  - 00 selects RD1_E.
  - 01 selects result_W.
  - 10 selects ALUresult_M (the registered output of this block).
  - 11 is treated as 00.
- forwardB_E selects the same way to produce fwdB.
- srcB = alusrc_E ? imm_E : fwdB. writedata_M is captured from fwdB, never from imm.
- ALU operations, all XLEN wide with wrap-around and no overflow flag:
  - 000: add.
  - 001: sub.
  - 010: and.
  - 011: or.
  - 100: xor.
  - 101: slt, signed; result is 1 or 0, zero-extended.
  - 110 and 111: result 0.
- zero = (ALU result == 0).
- Branch:
  - PCsrc_E = branch_E & zero.
  - PCtarget_E = PC_E + imm_E, modulo 2^XLEN.
- EX/MEM register, updated on posedge clk, priority rst > stall_M > flush_E > load:
  - stall_M=1: all *_M outputs hold, flush_E is ignored that cycle. PCsrc_E is still computed, and the upstream stage must not redirect while stalled.
  - flush_E=1 (no stall): regwrt_M=0, memwrite_M=0, resultctrl_M=0, RD_M=0. The data fields (PC_1DEM, writedata_M, ALUresult_M) also load 0.
  - Otherwise: all fields load the values from the current cycle.
- Latency: 1 cycle from E inputs to *_M outputs.
- Self-forwarding: forward select 10 reads the pre-edge ALUresult_M. Back-to-back dependent ALU ops therefore resolve with no stall.
- Reset deasserted mid-stream: the first edge after release loads normally. No partial state survives reset.

Decomposition:
- Package riscv_pkg holds:
  - ALU op constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT.
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - XLEN and REGW.
- One sub-module: alu (srcA, srcB, alucontrol → result, zero), purely combinational.
- The forwarding muxes and the EX/MEM register stay in execute_cycle.

Test Plan:
1. Reset: assert rst=1 asynchronously mid-cycle → all *_M outputs are 0 immediately, with no clock edge needed.
2. Add with immediate: RD1_E=5, imm_E=7, alusrc_E=1, alucontrol=000, regwrt_E=1, RD_E=3 → after one edge ALUresult_M=12, RD_M=3, regwrt_M=1.
3. Forwarding chain: cycle 1 computes 10+20=30. Cycle 2 uses forwardA_E=10, srcB=imm 1 → ALUresult_M=31. Cycle 3 uses forwardB_E=01, result_W=0xFFFFFFFF, RD1_E=1, alusrc=0, sub → 2.
4. Branch: beq with RD1_E=RD2_E=9, PC_E=0x100, imm_E=0xFFFFFFF8 → PCsrc_E=1, PCtarget_E=0xF8 in the same cycle. With RD2_E=8 → PCsrc_E=0.
5. Stall and flush:
   - stall_M=1 and flush_E=1 together → outputs are unchanged.
   - Next cycle flush_E=1 alone → regwrt_M=0, memwrite_M=0, ALUresult_M=0.
   - Then normal operation → new values load.
6. Store path and slt:
   - memwrite_E=1, forwardB_E=01, result_W=0xDEADBEEF, alusrc=1 → writedata_M=0xDEADBEEF, memwrite_M=1.
   - slt with -1 vs 1 → ALUresult_M=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, ALU op codes and forward selects for the RV32I execute stage
//
// Purpose: constants shared by execute_cycle and alu.
// Contents: XLEN, REGW, ALU_* operation codes, FWD_* operand source selects.

package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// rtl/execute_cycle_alu.sv - combinational RV32I ALU with zero flag
//
// Purpose: XLEN-wide add/sub/and/or/xor/slt, wrap-around arithmetic, no overflow flag.
// Ports:
//   srcA, srcB  in  operands
//   alucontrol  in  operation select (unused codes yield 0)
//   result      out ALU result
//   zero        out result == 0

module alu #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [2:0]      alucontrol,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  import riscv_pkg::*;

  logic lt_signed;

  assign lt_signed = $signed(srcA) < $signed(srcB);

  always_comb begin
    result = '0;
    case (alucontrol)
      ALU_ADD: result = srcA + srcB;
      ALU_SUB: result = srcA - srcB;
      ALU_AND: result = srcA & srcB;
      ALU_OR:  result = srcA | srcB;
      ALU_XOR: result = srcA ^ srcB;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, lt_signed};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RV32I execute stage with forwarding, beq resolution and EX/MEM register
//
// Purpose: selects forwarded operands, runs the ALU, resolves beq combinationally and
// registers the EX/MEM bundle consumed by memory_cycle (with stall hold and flush bubble).
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   regwrt_E..PC_1DE             ID/EX control and data inputs
//   forwardA_E, forwardB_E       operand source selects (00 RF, 01 WB, 10 MEM, 11 = RF)
//   result_W                     writeback-stage result for forwarding
//   stall_M, flush_E             hold / bubble control of the EX/MEM register
//   PCsrc_E, PCtarget_E          combinational branch decision and target
//   *_M                          registered EX/MEM bundle

module execute_cycle #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REGW = riscv_pkg::REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwrt_E,
  input  logic            memwrite_E,
  input  logic            resultctrl_E,
  input  logic            branch_E,
  input  logic            alusrc_E,
  input  logic [2:0]      alucontrol_E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] imm_E,
  input  logic [REGW-1:0] RD_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] PC_1DE,
  input  logic [1:0]      forwardA_E,
  input  logic [1:0]      forwardB_E,
  input  logic [XLEN-1:0] result_W,
  input  logic            stall_M,
  input  logic            flush_E,
  output logic            PCsrc_E,
  output logic [XLEN-1:0] PCtarget_E,
  output logic            regwrt_M,
  output logic            memwrite_M,
  output logic            resultctrl_M,
  output logic [REGW-1:0] RD_M,
  output logic [XLEN-1:0] PC_1DEM,
  output logic [XLEN-1:0] writedata_M,
  output logic [XLEN-1:0] ALUresult_M
);
  import riscv_pkg::*;

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // FWD_MEM reads the pre-edge ALUresult_M, so back-to-back dependent ops need no stall.
  always_comb begin
    srcA = RD1_E;
    case (forwardA_E)
      FWD_WB:  srcA = result_W;
      FWD_MEM: srcA = ALUresult_M;
      default: srcA = RD1_E;
    endcase
  end

  always_comb begin
    fwdB = RD2_E;
    case (forwardB_E)
      FWD_WB:  fwdB = result_W;
      FWD_MEM: fwdB = ALUresult_M;
      default: fwdB = RD2_E;
    endcase
  end

  assign srcB = alusrc_E ? imm_E : fwdB;

  alu #(.XLEN(XLEN)) u_alu (
    .srcA       (srcA),
    .srcB       (srcB),
    .alucontrol (alucontrol_E),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  assign PCsrc_E    = branch_E & alu_zero;
  assign PCtarget_E = PC_E + imm_E;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrt_M     <= 1'b0;
      memwrite_M   <= 1'b0;
      resultctrl_M <= 1'b0;
      RD_M         <= '0;
      PC_1DEM      <= '0;
      writedata_M  <= '0;
      ALUresult_M  <= '0;
    end else if (!stall_M) begin
      if (flush_E) begin
        regwrt_M     <= 1'b0;
        memwrite_M   <= 1'b0;
        resultctrl_M <= 1'b0;
        RD_M         <= '0;
        PC_1DEM      <= '0;
        writedata_M  <= '0;
        ALUresult_M  <= '0;
      end else begin
        regwrt_M     <= regwrt_E;
        memwrite_M   <= memwrite_E;
        resultctrl_M <= resultctrl_E;
        RD_M         <= RD_E;
        PC_1DEM      <= PC_1DE;
        // Store data is the forwarded rs2, never the immediate.
        writedata_M  <= fwdB;
        ALUresult_M  <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - scoreboard testbench for execute_cycle

module tb_execute_cycle;

  typedef struct packed {
    logic        regwrt;
    logic        memwrite;
    logic        resultctrl;
    logic [4:0]  rd;
    logic [31:0] pc1;
    logic [31:0] wd;
    logic [31:0] alu;
  } mexp_t;

  typedef struct packed {
    logic        pcsrc;
    logic [31:0] tgt;
  } cexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrt_E, memwrite_E, resultctrl_E, branch_E, alusrc_E;
  logic [2:0]  alucontrol_E;
  logic [31:0] RD1_E, RD2_E, imm_E, PC_E, PC_1DE, result_W;
  logic [4:0]  RD_E;
  logic [1:0]  forwardA_E, forwardB_E;
  logic        stall_M, flush_E;
  logic        PCsrc_E;
  logic [31:0] PCtarget_E;
  logic        regwrt_M, memwrite_M, resultctrl_M;
  logic [4:0]  RD_M;
  logic [31:0] PC_1DEM, writedata_M, ALUresult_M;

  int checks = 0;
  int errors = 0;

  mexp_t m_q[$];
  cexp_t c_q[$];
  event  async_chk;

  execute_cycle dut (
    .clk          (clk),
    .rst          (rst),
    .regwrt_E     (regwrt_E),
    .memwrite_E   (memwrite_E),
    .resultctrl_E (resultctrl_E),
    .branch_E     (branch_E),
    .alusrc_E     (alusrc_E),
    .alucontrol_E (alucontrol_E),
    .RD1_E        (RD1_E),
    .RD2_E        (RD2_E),
    .imm_E        (imm_E),
    .RD_E         (RD_E),
    .PC_E         (PC_E),
    .PC_1DE       (PC_1DE),
    .forwardA_E   (forwardA_E),
    .forwardB_E   (forwardB_E),
    .result_W     (result_W),
    .stall_M      (stall_M),
    .flush_E      (flush_E),
    .PCsrc_E      (PCsrc_E),
    .PCtarget_E   (PCtarget_E),
    .regwrt_M     (regwrt_M),
    .memwrite_M   (memwrite_M),
    .resultctrl_M (resultctrl_M),
    .RD_M         (RD_M),
    .PC_1DEM      (PC_1DEM),
    .writedata_M  (writedata_M),
    .ALUresult_M  (ALUresult_M)
  );

  always #5 clk = ~clk;

  // Registered-bundle monitor: one expectation per edge, plus the async-reset probe.
  initial begin
    mexp_t e, a;
    forever begin
      @(posedge clk or async_chk);
      #1;
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        a = '{regwrt_M, memwrite_M, resultctrl_M, RD_M, PC_1DEM, writedata_M, ALUresult_M};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ex_mem @%0t: got rw=%b mw=%b rc=%b rd=%0d pc1=%h wd=%h alu=%h, want rw=%b mw=%b rc=%b rd=%0d pc1=%h wd=%h alu=%h",
                   $time, a.regwrt, a.memwrite, a.resultctrl, a.rd, a.pc1, a.wd, a.alu,
                   e.regwrt, e.memwrite, e.resultctrl, e.rd, e.pc1, e.wd, e.alu);
        end
      end
    end
  end

  // Combinational branch monitor: checked mid low phase after inputs settle.
  initial begin
    cexp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (c_q.size() > 0) begin
        e = c_q.pop_front();
        checks++;
        if (PCsrc_E !== e.pcsrc || PCtarget_E !== e.tgt) begin
          errors++;
          $display("FAIL branch @%0t: got PCsrc=%b target=%h, want PCsrc=%b target=%h",
                   $time, PCsrc_E, PCtarget_E, e.pcsrc, e.tgt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    regwrt_E = 0; memwrite_E = 0; resultctrl_E = 0; branch_E = 0; alusrc_E = 0;
    alucontrol_E = 3'b000; RD1_E = 0; RD2_E = 0; imm_E = 0; RD_E = 0;
    PC_E = 0; PC_1DE = 0; forwardA_E = 2'b00; forwardB_E = 2'b00; result_W = 0;
    stall_M = 0; flush_E = 0;
  endtask

  // Called at a negedge with inputs set: queue the post-edge bundle and advance one cycle.
  task automatic cycle(input mexp_t e);
    m_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    cycle('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0});
    // Combinational outputs follow inputs during reset: beq of 0 vs 0 is taken.
    branch_E = 1; PC_E = 32'h40; imm_E = 32'h10;
    c_q.push_back('{1'b1, 32'h50});
    cycle('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0});
    rst = 1'b0;

    // Add with immediate
    clear_inputs();
    RD1_E = 5; imm_E = 7; alusrc_E = 1; regwrt_E = 1; RD_E = 3; RD2_E = 32'h55; PC_1DE = 32'h104;
    cycle('{1, 0, 0, 5'd3, 32'h104, 32'h55, 32'd12});

    // Forwarding chain
    clear_inputs();
    RD1_E = 10; RD2_E = 20; regwrt_E = 1; RD_E = 4; PC_1DE = 32'h108;
    cycle('{1, 0, 0, 5'd4, 32'h108, 32'd20, 32'd30});
    clear_inputs();
    forwardA_E = 2'b10; RD1_E = 999; alusrc_E = 1; imm_E = 1; RD2_E = 7; regwrt_E = 1; RD_E = 5; PC_1DE = 32'h10c;
    cycle('{1, 0, 0, 5'd5, 32'h10c, 32'd7, 32'd31});
    clear_inputs();
    RD1_E = 1; forwardB_E = 2'b01; result_W = 32'hFFFFFFFF; RD2_E = 77; alucontrol_E = 3'b001; regwrt_E = 1; RD_E = 6; PC_1DE = 32'h110;
    cycle('{1, 0, 0, 5'd6, 32'h110, 32'hFFFFFFFF, 32'd2});
    clear_inputs();
    forwardA_E = 2'b11; RD1_E = 32'h10; result_W = 32'h999; forwardB_E = 2'b10; alucontrol_E = 3'b011; regwrt_E = 1; RD_E = 7; PC_1DE = 32'h114;
    cycle('{1, 0, 0, 5'd7, 32'h114, 32'd2, 32'h12});

    // Branch taken / not taken
    clear_inputs();
    branch_E = 1; RD1_E = 9; RD2_E = 9; alucontrol_E = 3'b001; PC_E = 32'h100; imm_E = 32'hFFFFFFF8; PC_1DE = 32'h104;
    c_q.push_back('{1'b1, 32'hF8});
    cycle('{0, 0, 0, 5'd0, 32'h104, 32'd9, 32'd0});
    RD2_E = 8;
    c_q.push_back('{1'b0, 32'hF8});
    cycle('{0, 0, 0, 5'd0, 32'h104, 32'd8, 32'd1});

    // Stall and flush
    clear_inputs();
    RD1_E = 3; RD2_E = 4; regwrt_E = 1; resultctrl_E = 1; RD_E = 6; PC_1DE = 32'h200;
    cycle('{1, 0, 1, 5'd6, 32'h200, 32'd4, 32'd7});
    clear_inputs();
    stall_M = 1; flush_E = 1; RD1_E = 100; RD2_E = 5; memwrite_E = 1; RD_E = 9; PC_1DE = 32'h300;
    cycle('{1, 0, 1, 5'd6, 32'h200, 32'd4, 32'd7});
    stall_M = 0; flush_E = 1; regwrt_E = 1;
    cycle('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0});
    clear_inputs();
    RD1_E = 1; RD2_E = 3; alucontrol_E = 3'b100; regwrt_E = 1; RD_E = 8; PC_1DE = 32'h208;
    cycle('{1, 0, 0, 5'd8, 32'h208, 32'd3, 32'd2});

    // Store path, and/slt/unused op
    clear_inputs();
    memwrite_E = 1; forwardB_E = 2'b01; result_W = 32'hDEADBEEF; alusrc_E = 1; RD1_E = 32'h1000; imm_E = 8; RD2_E = 1; PC_1DE = 32'h20c;
    cycle('{0, 1, 0, 5'd0, 32'h20c, 32'hDEADBEEF, 32'h1008});
    clear_inputs();
    RD1_E = 32'hFFFFFFFF; RD2_E = 1; alucontrol_E = 3'b101; regwrt_E = 1; RD_E = 10;
    cycle('{1, 0, 0, 5'd10, 32'h0, 32'd1, 32'd1});
    RD1_E = 1; RD2_E = 32'hFFFFFFFF;
    cycle('{1, 0, 0, 5'd10, 32'h0, 32'hFFFFFFFF, 32'd0});
    RD1_E = 32'hF0F0; RD2_E = 32'h0FF0; alucontrol_E = 3'b010; resultctrl_E = 1;
    cycle('{1, 0, 1, 5'd10, 32'h0, 32'h0FF0, 32'h00F0});
    alucontrol_E = 3'b110;
    cycle('{1, 0, 1, 5'd10, 32'h0, 32'h0FF0, 32'h0});

    // Asynchronous reset mid-cycle, then recovery
    clear_inputs();
    RD1_E = 1; RD2_E = 1; regwrt_E = 1; RD_E = 2; PC_1DE = 32'h400;
    m_q.push_back('{1, 0, 0, 5'd2, 32'h400, 32'd1, 32'd2});
    @(posedge clk);
    #3;
    rst = 1'b1;
    m_q.push_back('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0});
    ->async_chk;
    @(negedge clk);
    cycle('{0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0});
    rst = 1'b0;
    RD1_E = 6; RD2_E = 2; alucontrol_E = 3'b001;
    cycle('{1, 0, 0, 5'd2, 32'h400, 32'd2, 32'd4});

    @(negedge clk);
    checks++;
    if (m_q.size() != 0 || c_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", m_q.size(), c_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
